wb_commit: RTL and testbench
============================

# wb_commit

Write-back commit unit at the end of the pipeline, producing the register-file write port (`REG_write`, `REG_write_addr`, `REG_write_data`) consumed by the ID stage.
- Accepts completed instructions from EX/MEM through a valid/ready handshake into an in-order queue of `DEPTH` entries.
- For loads, waits for the data-memory read response before committing.
- Retires at most one register write per cycle and exports a pending-destination mask so ID can stall on RAW hazards.

## Interface
- `DEPTH`, 2: queue entries; power of two, ≥ 2.
- `WORD`, 32: data width.
- `REG_LOG`, 5: register address width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EX/MEM offers an instruction.
- `in_ready`  out  1  queue can accept; combinational `count < DEPTH`.
- `in_rd`  in  REG_LOG  destination register.
- `in_result`  in  WORD  ALU result (ignored for loads).
- `in_REG_WB`  in  2  bit1 = write register, bit0 = data comes from memory (load).
- `mem_rvalid`  in  1  data-memory read response valid.
- `mem_rready`  out  1  high when the head entry is a valid load.
- `mem_rdata`  in  WORD  load data.
- `REG_write`  out  1  register-file write enable, registered.
- `REG_write_addr`  out  REG_LOG  write address, registered.
- `REG_write_data`  out  WORD  write data, registered.
- `busy_mask`  out  2^REG_LOG  bit r set while a write to r is queued or being presented on the write port.

## Operation
- Push: `in_valid && in_ready` at an edge stores {rd, result, REG_WB} at the tail.
  - An entry with `in_REG_WB[1]=0`, or with `in_rd=0`, is stored with its write bit cleared. It still occupies a slot and retires in order, but never writes and never sets `busy_mask`.
- Head processing, when the queue is non-empty:
  - Non-load (`REG_WB[0]=0`): pops at the next edge. The output register loads `REG_write = wbit`, addr = rd, data = result.
  - Load: `mem_rready=1`. The entry pops at the edge where `mem_rvalid && mem_rready`; the output register loads `REG_write = wbit`, addr = rd, data = `mem_rdata`. While `mem_rvalid=0` the head stalls indefinitely.
  - A load with wbit = 0 still waits for and consumes its memory response.
- Output register:
  - Updates every edge.
  - When no pop occurs, `REG_write` loads 0; addr and data hold their previous values.
- Push and pop at the same edge are both performed; count is unchanged. `in_ready` does not consider a same-cycle pop: a full queue refuses input even when popping.
- `mem_rvalid` while `mem_rready=0` is a protocol error and is ignored.
- `busy_mask` is combinational: the OR of the one-hot rd of every queued entry with wbit set, plus the output-register rd when `REG_write=1`. Bit 0 is always 0.
- Pointers are `log2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `log2(DEPTH)+1` bits.

## Timing
- Reset (`rst=0`, asynchronous):
  - Count and pointers return to 0.
  - `REG_write`, `REG_write_addr`, `REG_write_data` are all 0.
  - `busy_mask`=0, `mem_rready`=0, `in_ready`=1 (while reset is held and after release).
- Reset mid-load discards all queued entries and any pending response. No write is presented after release.
- Non-load latency: accepted at edge E, popped at E+1, `REG_write` high during the cycle after E+1 for exactly one cycle. The RF captures it at E+2.
- Load latency: `REG_write` is high the cycle after the memory handshake edge.
- Throughput: one commit per cycle for back-to-back non-loads.
- An empty queue keeps `REG_write` at 0 after one cycle.

## Test plan
- Reset, then push rd=3, result=0x1234_5678, REG_WB=2'b10 at edge 1.
  - `REG_write`=1, addr=3, data=0x12345678 during exactly one cycle after edge 2.
  - `busy_mask[3]`=1 from after edge 1 until `REG_write` drops.
- Push a load to rd=5 with REG_WB=2'b11, then an ALU op to rd=6.
  - Hold `mem_rvalid`=0 for 4 cycles: `mem_rready`=1, no writes, `in_ready`=0 once count=DEPTH.
  - Then give `mem_rvalid`=1 with data 0xCAFEBABE: the write to r5=0xCAFEBABE appears first, then r6 on the following cycle.
- Push rd=0 with write set, and separately rd=7 with REG_WB=2'b00.
  - Each pops in one cycle.
  - `REG_write` stays 0 and `busy_mask` stays 0 throughout.
- Stream 8 back-to-back ALU ops with rd=1..8 while holding `in_valid`=1.
  - `in_ready` stays 1.
  - Writes appear on consecutive cycles in order, data intact across pointer wrap.
- Queue a load (no response yet) plus one ALU op, then pulse `rst` low for half a cycle.
  - All outputs are 0 immediately, even between edges.
  - A later `mem_rvalid` is ignored.
  - No write ever occurs for the flushed entries.

Source files
------------

// File: rtl/wb_commit.sv
// rtl/wb_commit.sv - in-order write-back commit queue driving the register-file write port
// Loads hold the queue head until their memory response arrives; busy_mask exposes pending destinations.
module wb_commit #(
    parameter int DEPTH   = 2,
    parameter int WORD    = 32,
    parameter int REG_LOG = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_LOG-1:0]        in_rd,
    input  logic [WORD-1:0]           in_result,
    input  logic [1:0]                in_REG_WB,
    input  logic                      mem_rvalid,
    output logic                      mem_rready,
    input  logic [WORD-1:0]           mem_rdata,
    output logic                      REG_write,
    output logic [REG_LOG-1:0]        REG_write_addr,
    output logic [WORD-1:0]           REG_write_data,
    output logic [(1<<REG_LOG)-1:0]   busy_mask
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REG_LOG-1:0] q_rd   [DEPTH];
    logic [WORD-1:0]    q_data [DEPTH];
    logic [DEPTH-1:0]   q_valid;
    logic [DEPTH-1:0]   q_wbit;
    logic [DEPTH-1:0]   q_load;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;

    logic head_present;
    logic head_load;
    logic push;
    logic pop;

    assign head_present = (count != '0);
    assign head_load    = q_load[rd_ptr];
    assign in_ready     = (count < (PW+1)'(DEPTH));
    assign mem_rready   = head_present && head_load;
    assign push         = in_valid && in_ready;
    // A load pops only on its response; a response with no load at the head is ignored.
    assign pop          = head_present && (!head_load || mem_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_rd[i]   <= '0;
                q_data[i] <= '0;
            end
            q_valid        <= '0;
            q_wbit         <= '0;
            q_load         <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            REG_write      <= 1'b0;
            REG_write_addr <= '0;
            REG_write_data <= '0;
        end else begin
            if (push) begin
                q_rd[wr_ptr]    <= in_rd;
                q_data[wr_ptr]  <= in_result;
                q_wbit[wr_ptr]  <= in_REG_WB[1] && (in_rd != '0);
                q_load[wr_ptr]  <= in_REG_WB[0];
                q_valid[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            // Push never targets the head slot here: push requires a non-full queue.
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
                REG_write_addr  <= q_rd[rd_ptr];
                REG_write_data  <= head_load ? mem_rdata : q_data[rd_ptr];
            end
            REG_write <= pop && q_wbit[rd_ptr];
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && q_wbit[i]) busy_mask[q_rd[i]] = 1'b1;
        end
        if (REG_write) busy_mask[REG_write_addr] = 1'b1;
        busy_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_commit.sv
// tb/tb_wb_commit.sv - directed and random checks of wb_commit against a queue-based reference model
module tb_wb_commit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [1:0]  in_REG_WB;
    logic        mem_rvalid;
    logic        mem_rready;
    logic [31:0] mem_rdata;
    logic        REG_write;
    logic [4:0]  REG_write_addr;
    logic [31:0] REG_write_data;
    logic [31:0] busy_mask;

    wb_commit #(.DEPTH(DEPTH), .WORD(32), .REG_LOG(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_result(in_result), .in_REG_WB(in_REG_WB),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rdata(mem_rdata),
        .REG_write(REG_write), .REG_write_addr(REG_write_addr),
        .REG_write_data(REG_write_data), .busy_mask(busy_mask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wbit;
        logic        load;
    } ent_t;

    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_we   = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    // Applies the rules of one clock edge to the reference queue using the currently driven inputs.
    task automatic model_step();
        ent_t e;
        bit   do_push;
        bit   do_pop;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = (mq.size() > 0) && (!mq[0].load || mem_rvalid);
        if (do_pop) begin
            m_we   = mq[0].wbit;
            m_addr = mq[0].rd;
            m_data = mq[0].load ? mem_rdata : mq[0].data;
            void'(mq.pop_front());
        end else begin
            m_we = 1'b0;
        end
        if (do_push) begin
            e.rd   = in_rd;
            e.data = in_result;
            e.wbit = in_REG_WB[1] && (in_rd != 0);
            e.load = in_REG_WB[0];
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_mask;
        exp_mask = '0;
        foreach (mq[i]) if (mq[i].wbit) exp_mask[mq[i].rd] = 1'b1;
        if (m_we) exp_mask[m_addr] = 1'b1;
        chk("in_ready",   in_ready,       mq.size() < DEPTH);
        chk("mem_rready", mem_rready,     (mq.size() > 0) && mq[0].load);
        chk("reg_write",  REG_write,      m_we);
        chk("write_addr", REG_write_addr, m_addr);
        chk("write_data", REG_write_data, m_data);
        chk("busy_mask",  busy_mask,      exp_mask);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] res, input logic [1:0] wb);
        in_valid  = v;
        in_rd     = rd;
        in_result = res;
        in_REG_WB = wb;
    endtask

    initial begin
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        model_reset();

        // Reset held across edges
        #2;
        chk("rst_write",   REG_write,      1'b0);
        chk("rst_ready",   in_ready,       1'b1);
        repeat (2) @(negedge clk);
        chk("rst_addr",    REG_write_addr, 5'd0);
        chk("rst_data",    REG_write_data, 32'd0);
        chk("rst_busy",    busy_mask,      32'd0);
        chk("rst_rready",  mem_rready,     1'b0);
        rst = 1'b1;

        // Single ALU write to r3
        drive(1'b1, 5'd3, 32'h1234_5678, 2'b10);
        tick();
        chk("t1_busy3", busy_mask[3], 1'b1);
        chk("t1_nowr",  REG_write,    1'b0);
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        tick();
        chk("t1_we",    REG_write,      1'b1);
        chk("t1_addr",  REG_write_addr, 5'd3);
        chk("t1_data",  REG_write_data, 32'h1234_5678);
        tick();
        chk("t1_drop",  REG_write,    1'b0);
        chk("t1_clr3",  busy_mask[3], 1'b0);

        // Load to r5 stalls, then ALU to r6 behind it
        drive(1'b1, 5'd5, 32'hDEAD_0000, 2'b11);
        tick();
        drive(1'b1, 5'd6, 32'h0000_0066, 2'b10);
        tick();
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        chk("t2_full", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_stall_rready", mem_rready, 1'b1);
            chk("t2_stall_nowr",   REG_write,  1'b0);
            chk("t2_stall_busy",   busy_mask,  32'h0000_0060);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_BABE;
        tick();
        mem_rvalid = 1'b0;
        chk("t2_r5_addr", REG_write_addr, 5'd5);
        chk("t2_r5_data", REG_write_data, 32'hCAFE_BABE);
        tick();
        chk("t2_r6_we",   REG_write,      1'b1);
        chk("t2_r6_addr", REG_write_addr, 5'd6);
        tick();

        // rd=0 with write set, and rd=7 without write
        drive(1'b1, 5'd0, 32'h1111_1111, 2'b10);
        tick();
        chk("t3_busy", busy_mask, 32'd0);
        drive(1'b1, 5'd7, 32'h7777_7777, 2'b00);
        tick();
        chk("t3_busy", busy_mask, 32'd0);
        chk("t3_we",   REG_write, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        repeat (2) begin
            tick();
            chk("t3_we",   REG_write, 1'b0);
            chk("t3_busy", busy_mask, 32'd0);
        end

        // Eight back-to-back ALU ops across pointer wrap
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 5'(i), 32'hA000_0000 + 32'(i), 2'b10);
            tick();
            chk("t4_ready", in_ready, 1'b1);
            if (i > 1) begin
                chk("t4_addr", REG_write_addr, 5'(i - 1));
                chk("t4_data", REG_write_data, 32'hA000_0000 + 32'(i - 1));
            end
        end
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        repeat (3) tick();

        // Reset pulse with a load and an ALU op queued
        drive(1'b1, 5'd9, 32'd0, 2'b11);
        tick();
        drive(1'b1, 5'd10, 32'h0000_00AA, 2'b10);
        tick();
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        #1 rst = 1'b0;
        #1;
        model_reset();
        chk("t5_we",     REG_write,      1'b0);
        chk("t5_addr",   REG_write_addr, 5'd0);
        chk("t5_data",   REG_write_data, 32'd0);
        chk("t5_busy",   busy_mask,      32'd0);
        chk("t5_rready", mem_rready,     1'b0);
        chk("t5_ready",  in_ready,       1'b1);
        #2 rst = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        repeat (3) begin
            tick();
            chk("t5_nowr", REG_write, 1'b0);
        end
        mem_rvalid = 1'b0;

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(), 2'($urandom_range(0, 3)));
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom();
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 2'b00);
        mem_rvalid = 1'b1;
        repeat (4) tick();
        mem_rvalid = 1'b0;
        tick();
        chk("drain_we",   REG_write, 1'b0);
        chk("drain_busy", busy_mask, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
